// File: rtl/tdc_stream_tx.sv
// TDC hit capture and stream transmitter.
// Captures per-pixel timestamps in a window, then streams the slots out.
module tdc_stream_tx #(
  parameter int NP        = 12,
  parameter int DATA_NUM  = 2,
  parameter int PIXEL_NUM = 4,
  parameter int ACQ_NUM   = 3,
  parameter int WIN_CYC   = 16
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         acq_start,
  input  logic                         hit_valid,
  input  logic [$clog2(PIXEL_NUM)-1:0] hit_pixel,
  input  logic [NP-1:0]                hit_time,
  output logic                         wrEn,
  output logic [NP-1:0]                data,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   drop_cnt
);

  localparam int N  = PIXEL_NUM * DATA_NUM;
  localparam int PW = $clog2(PIXEL_NUM);
  localparam int FW = $clog2(DATA_NUM + 1);
  localparam int WW = $clog2(N + 1);
  localparam int CW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  localparam logic [PW:0]   PIX_LIM  = (PW+1)'(PIXEL_NUM);
  localparam logic [FW-1:0] FILL_LIM = FW'(DATA_NUM);
  localparam logic [WW-1:0] WORD_END = WW'(N);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_CYC - 1);
  localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_NUM - 1);
  localparam logic [NP-1:0] NO_HIT   = '1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [NP-1:0] mem [N];
  logic [FW-1:0] fill [PIXEL_NUM];
  logic [CW-1:0] win_cnt;
  logic [WW-1:0] word_idx;
  logic [AW-1:0] acq_cnt;
  logic          start;
  logic          to_send;
  logic          to_idle;
  logic          hit_ok;
  logic [FW-1:0] fill_sel;
  logic [NP-1:0] rd_word;
  logic [NP-1:0] first_word;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and transition strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    to_send   = 1'b0;
    to_idle   = 1'b0;
    unique case (state)
      IDLE: begin
        if (acq_start) begin
          state_nxt = CAPTURE;
          start     = 1'b1;
        end
      end
      CAPTURE: begin
        if (win_cnt == WIN_LAST) begin
          state_nxt = SEND;
          to_send   = 1'b1;
        end
      end
      SEND: begin
        if (word_idx == WORD_END) begin
          state_nxt = IDLE;
          to_idle   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hit qualification against window, marker, range and slot space.
  always_comb begin
    fill_sel = '0;
    for (int p = 0; p < PIXEL_NUM; p++)
      if (hit_pixel == PW'(p)) fill_sel = fill[p];
    hit_ok = hit_valid
          && (state == CAPTURE)
          && (hit_time != NO_HIT)
          && ({1'b0, hit_pixel} < PIX_LIM)
          && (fill_sel < FILL_LIM);
  end

  // Word read mux; first word bypasses a hit landing on the last window cycle.
  always_comb begin
    rd_word = mem[0];
    for (int i = 0; i < N; i++)
      if (word_idx == WW'(i)) rd_word = mem[i];
    first_word = mem[0];
    if (hit_ok && hit_pixel == '0 && fill[0] == '0)
      first_word = hit_time;
  end

  // Buffer, counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      win_cnt    <= '0;
      word_idx   <= '0;
      acq_cnt    <= '0;
      wrEn       <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      for (int p = 0; p < PIXEL_NUM; p++) fill[p] <= '0;
      for (int i = 0; i < N; i++) mem[i] <= NO_HIT;
    end else begin
      wrEn       <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      if (hit_valid && !hit_ok && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (start) begin
        win_cnt <= '0;
        for (int p = 0; p < PIXEL_NUM; p++) fill[p] <= '0;
        for (int i = 0; i < N; i++) mem[i] <= NO_HIT;
      end
      if (state == CAPTURE) begin
        win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
        for (int p = 0; p < PIXEL_NUM; p++) begin
          if (hit_ok && hit_pixel == PW'(p)) begin
            fill[p] <= fill[p] + 1'b1;
            for (int s = 0; s < DATA_NUM; s++)
              if (fill[p] == FW'(s)) mem[p*DATA_NUM+s] <= hit_time;
          end
        end
      end
      if (to_send) begin
        wrEn     <= 1'b1;
        data     <= first_word;
        word_idx <= WW'(1);
      end
      if (state == SEND && !to_idle) begin
        wrEn     <= 1'b1;
        data     <= rd_word;
        word_idx <= word_idx + 1'b1;
      end
      if (to_idle) begin
        word_idx <= '0;
        if (acq_cnt == ACQ_LAST) begin
          acq_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          acq_cnt <= acq_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_stream_tx.sv
// Directed testbench for tdc_stream_tx.
// Main instance uses defaults; a 5-pixel instance exercises pixel range.
module tb_tdc_stream_tx;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        acq_start = 1'b0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_pixel = '0;
  logic [11:0] hit_time = '0;
  logic        wrEn;
  logic [11:0] data;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  logic        acq5 = 1'b0;
  logic        hv5 = 1'b0;
  logic [2:0]  hp5 = '0;
  logic [11:0] ht5 = '0;
  logic        wr5;
  logic [11:0] d5;
  logic        busy5;
  logic        fd5;
  logic [7:0]  drop5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  int fd_cnt = 0;

  logic [11:0] got [16];
  int          got_n;
  int          got_lat;
  int          got_bad;
  logic        got_fd;

  tdc_stream_tx u_dut (
    .clk(clk), .res(res), .acq_start(acq_start),
    .hit_valid(hit_valid), .hit_pixel(hit_pixel),
    .hit_time(hit_time), .wrEn(wrEn), .data(data),
    .busy(busy), .frame_done(frame_done),
    .drop_cnt(drop_cnt)
  );

  tdc_stream_tx #(.PIXEL_NUM(5)) u_dut5 (
    .clk(clk), .res(res), .acq_start(acq5),
    .hit_valid(hv5), .hit_pixel(hp5),
    .hit_time(ht5), .wrEn(wr5), .data(d5),
    .busy(busy5), .frame_done(fd5),
    .drop_cnt(drop5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    acq_start = 1'b1;
    step();
    acq_start = 1'b0;
    t_start = cyc;
  endtask

  task automatic hit(input logic [1:0] p, input logic [11:0] t);
    hit_valid = 1'b1;
    hit_pixel = p;
    hit_time  = t;
    step();
    hit_valid = 1'b0;
  endtask

  task automatic collect(input int pulse_at);
    int waited;
    waited  = 0;
    got_n   = 0;
    got_bad = 0;
    while (wrEn !== 1'b1 && waited < 40) begin
      if (data !== 12'h000) got_bad++;
      step();
      waited++;
    end
    got_lat = cyc - t_start;
    while (wrEn === 1'b1 && got_n < 16) begin
      got[got_n] = data;
      acq_start = (got_n == pulse_at);
      got_n++;
      step();
    end
    acq_start = 1'b0;
    got_fd = frame_done;
    if (data !== 12'h000) got_bad++;
  endtask

  task automatic test_reset();
    res = 1'b1;
    step();
    step();
    checks++;
    if (wrEn !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrEn got %b want 0", wrEn);
    end
    checks++;
    if (data !== 12'h000) begin
      errors++;
      $display("FAIL reset_data got %h want 000", data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd got %b want 0", frame_done);
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop got %0d want 0", drop_cnt);
    end
    res = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [11:0] exp [8];
    exp = '{12'h010, 12'h011, 12'hFFF, 12'hFFF,
            12'h3A0, 12'hFFF, 12'hFFF, 12'hFFF};
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_cap got %b want 1", busy);
    end
    hit(2'd0, 12'h010);
    hit(2'd2, 12'h3A0);
    hit(2'd0, 12'h011);
    collect(-1);
    checks++;
    if (got_n != 8) begin
      errors++;
      $display("FAIL basic_count got %0d want 8", got_n);
    end
    checks++;
    if (got_lat != 16) begin
      errors++;
      $display("FAIL basic_latency got %0d want 16", got_lat);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_word%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (got_bad != 0) begin
      errors++;
      $display("FAIL basic_idle_data got %0d nonzero want 0", got_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end got %b want 0", busy);
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL basic_drop got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] exp [8];
    exp = '{12'hFFF, 12'hFFF, 12'h111, 12'h222,
            12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    pulse_start();
    hit(2'd1, 12'h111);
    hit(2'd1, 12'h222);
    hit(2'd1, 12'h333);
    collect(-1);
    checks++;
    if (got_n != 8) begin
      errors++;
      $display("FAIL ovf_count got %0d want 8", got_n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL ovf_word%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_drop got %0d want 1", drop_cnt);
    end
  endtask

  task automatic test_frame();
    int fd0;
    res = 1'b1;
    step();
    res = 1'b0;
    fd0 = fd_cnt;
    for (int a = 0; a < 4; a++) begin
      pulse_start();
      collect(-1);
      checks++;
      if (got_n != 8) begin
        errors++;
        $display("FAIL frame%0d_count got %0d want 8", a, got_n);
      end
      checks++;
      if (got_lat != 16) begin
        errors++;
        $display("FAIL frame%0d_lat got %0d want 16", a, got_lat);
      end
      checks++;
      if (got_fd !== (a == 2)) begin
        errors++;
        $display("FAIL frame%0d_fd got %b want %b", a, got_fd, a == 2);
      end
    end
    step();
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL frame_pulses got %0d want 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_abort();
    int waited;
    int seen;
    pulse_start();
    hit(2'd0, 12'h0AB);
    waited = 0;
    while (wrEn !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    step();
    step();
    step();
    checks++;
    if (wrEn !== 1'b1 || data !== 12'hFFF) begin
      errors++;
      $display("FAIL abort_word3 got %b/%h want 1/fff", wrEn, data);
    end
    res = 1'b1;
    step();
    res = 1'b0;
    checks++;
    if (wrEn !== 1'b0 || data !== 12'h000) begin
      errors++;
      $display("FAIL abort_out got %b/%h want 0/000", wrEn, data);
    end
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got %b/%b want 0/0", busy, frame_done);
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_drop got %0d want 0", drop_cnt);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (wrEn !== 1'b0 || busy !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active want 0", seen);
    end
    pulse_start();
    collect(-1);
    checks++;
    if (got_n != 8) begin
      errors++;
      $display("FAIL abort_count got %0d want 8", got_n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 12'hFFF) begin
        errors++;
        $display("FAIL abort_word%0d got %h want fff", i, got[i]);
      end
    end
    checks++;
    if (got_fd !== 1'b0) begin
      errors++;
      $display("FAIL abort_fd got %b want 0", got_fd);
    end
  endtask

  task automatic test_last_cycle();
    int seen;
    pulse_start();
    repeat (15) step();
    hit(2'd0, 12'h0C1);
    collect(2);
    checks++;
    if (got_n != 8) begin
      errors++;
      $display("FAIL last_count got %0d want 8", got_n);
    end
    checks++;
    if (got_lat != 16) begin
      errors++;
      $display("FAIL last_lat got %0d want 16", got_lat);
    end
    checks++;
    if (got[0] !== 12'h0C1) begin
      errors++;
      $display("FAIL last_word0 got %h want 0c1", got[0]);
    end
    checks++;
    if (got[1] !== 12'hFFF) begin
      errors++;
      $display("FAIL last_word1 got %h want fff", got[1]);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || wrEn !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL last_ignored got %0d active want 0", seen);
    end
  endtask

  task automatic test_reject();
    int waited;
    int n;
    logic [11:0] w;
    hv5 = 1'b1;
    hp5 = 3'd0;
    ht5 = 12'h055;
    step();
    hv5 = 1'b0;
    acq5 = 1'b1;
    step();
    acq5 = 1'b0;
    hv5 = 1'b1;
    hp5 = 3'd5;
    ht5 = 12'h123;
    step();
    hp5 = 3'd1;
    ht5 = 12'hFFF;
    step();
    hp5 = 3'd4;
    ht5 = 12'h044;
    step();
    hv5 = 1'b0;
    waited = 0;
    while (wr5 !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    n = 0;
    while (wr5 === 1'b1 && n < 16) begin
      w = (n == 8) ? 12'h044 : 12'hFFF;
      checks++;
      if (d5 !== w) begin
        errors++;
        $display("FAIL rej_word%0d got %h want %h", n, d5, w);
      end
      n++;
      step();
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL rej_count got %0d want 10", n);
    end
    checks++;
    if (drop5 !== 8'd3) begin
      errors++;
      $display("FAIL rej_drop got %0d want 3", drop5);
    end
    hv5 = 1'b1;
    hp5 = 3'd0;
    ht5 = 12'h001;
    repeat (260) step();
    hv5 = 1'b0;
    step();
    checks++;
    if (drop5 !== 8'hFF) begin
      errors++;
      $display("FAIL rej_saturate got %0d want 255", drop5);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_frame();
    test_abort();
    test_last_cycle();
    test_reject();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
